// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: round-robin grants up to NUM_CDB writeback requesters
// per cycle and packs the winners, in scan order, onto registered CDB lanes.
module cdb_arbiter #(
    parameter  int NUM_REQ = 6,
    parameter  int NUM_CDB = 4,
    parameter  int TAG_W   = 6,
    parameter  int DATA_W  = 32,
    localparam int CNT_W   = $clog2(NUM_CDB + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush_i,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]    req_tag_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    output logic [NUM_CDB-1:0]               cdb_valid_o,
    output logic [NUM_CDB-1:0][TAG_W-1:0]    cdb_tag_o,
    output logic [NUM_CDB-1:0][DATA_W-1:0]   cdb_val_o,
    output logic [CNT_W-1:0]                 grant_cnt_o
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LANE_W = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;

    logic [PTR_W-1:0]               rr_ptr_r;
    logic [PTR_W-1:0]               ptr_nxt_s;
    logic [PTR_W-1:0]               last_s;
    logic [NUM_REQ-1:0]             grant_s;
    logic [NUM_CDB-1:0]             lane_valid_s;
    logic [NUM_CDB-1:0][TAG_W-1:0]  lane_tag_s;
    logic [NUM_CDB-1:0][DATA_W-1:0] lane_val_s;
    logic [CNT_W-1:0]               cnt_s;

    logic [NUM_CDB-1:0]             cdb_valid_r;
    logic [NUM_CDB-1:0][TAG_W-1:0]  cdb_tag_r;
    logic [NUM_CDB-1:0][DATA_W-1:0] cdb_val_r;
    logic [CNT_W-1:0]               grant_cnt_r;

    // Round-robin scan from rr_ptr; the k-th winner lands on lane k, unused lanes stay zero.
    always_comb begin : grant_scan
        int idx;
        int n;
        grant_s      = '0;
        lane_valid_s = '0;
        lane_tag_s   = '0;
        lane_val_s   = '0;
        last_s       = rr_ptr_r;
        n            = 0;
        idx          = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_r) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (!flush_i && req_valid_i[PTR_W'(idx)] && (n < NUM_CDB)) begin
                grant_s[PTR_W'(idx)]     = 1'b1;
                lane_valid_s[LANE_W'(n)] = 1'b1;
                lane_tag_s[LANE_W'(n)]   = req_tag_i[PTR_W'(idx)];
                lane_val_s[LANE_W'(n)]   = req_data_i[PTR_W'(idx)];
                last_s                   = PTR_W'(idx);
                n                        = n + 1;
            end else begin
                n = n;
            end
        end
        cnt_s = CNT_W'(n);
        if (n == 0) begin
            ptr_nxt_s = rr_ptr_r;
        end else if (int'(last_s) == NUM_REQ - 1) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = PTR_W'(int'(last_s) + 1);
        end
    end

    // Lane registers and round-robin pointer; flush needs no branch since it blocks every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r    <= '0;
            cdb_valid_r <= '0;
            cdb_tag_r   <= '0;
            cdb_val_r   <= '0;
            grant_cnt_r <= '0;
        end else begin
            rr_ptr_r    <= ptr_nxt_s;
            cdb_valid_r <= lane_valid_s;
            cdb_tag_r   <= lane_tag_s;
            cdb_val_r   <= lane_val_s;
            grant_cnt_r <= cnt_s;
        end
    end

    // Ready is combinational so a requester learns of its grant in the same cycle.
    assign req_ready_o = grant_s & {NUM_REQ{rst_n}};
    assign cdb_valid_o = cdb_valid_r;
    assign cdb_tag_o   = cdb_tag_r;
    assign cdb_val_o   = cdb_val_r;
    assign grant_cnt_o = grant_cnt_r;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the 4 common-data-bus (CDB) lanes among up to NUM_REQ functional-unit writeback requesters: ALU0, ALU1, LSU, MUL, DIV, BRU.
- Each cycle it grants at most NUM_CDB requesters in round-robin order and packs the winners onto lanes 0..k-1.
- Lane outputs are registered, then broadcast to the issue stage's wakeup ports (cdb_valid/cdb_tag/cdb_val) and to the ROB.

Parameters:
- NUM_REQ, 6, number of writeback requesters (2..8).
- NUM_CDB, 4, number of CDB lanes (1..NUM_REQ).
- TAG_W, 6, physical/ROB tag width.
- DATA_W, 32, result width (Cfg.ILEN).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  pipeline flush, synchronous.
- req_valid_i  in  NUM_REQ  requester i has a result.
- req_tag_i  in  TAG_W x NUM_REQ  destination tag per requester.
- req_data_i  in  DATA_W x NUM_REQ  result value per requester.
- req_ready_o  out  NUM_REQ  grant; the transfer completes when valid and ready are both high.
- cdb_valid_o  out  NUM_CDB  lane valid, registered.
- cdb_tag_o  out  TAG_W x NUM_CDB  lane tag, registered.
- cdb_val_o  out  DATA_W x NUM_CDB  lane value, registered.
- grant_cnt_o  out  $clog2(NUM_CDB+1)  number of lanes valid this cycle (popcount of cdb_valid_o).

Behaviour:
- Reset (rst_n low, asynchronous):
  - cdb_valid_o = 0, cdb_tag_o = 0, cdb_val_o = 0.
  - grant_cnt_o = 0, rr_ptr = 0.
  - req_ready_o = 0 while reset is asserted.
- State:
  - rr_ptr, $clog2(NUM_REQ) bits: the highest-priority requester index.
  - Output lane registers.
- Grant, combinational in cycle N:
  - Scan requesters in order rr_ptr, rr_ptr+1, ... wrapping mod NUM_REQ.
  - The first NUM_CDB requesters with req_valid_i=1 are granted.
  - req_ready_o[i] = 1 only for granted i. req_ready_o may depend combinationally on req_valid_i.
  - Requesters must hold valid, tag and data stable until granted.
- Lane packing:
  - The k-th granted requester in scan order (k=0..) is placed on lane k.
  - Lanes k >= number of grants are invalid. Their tag and data are 0 (no stale payload).
- Latency:
  - A grant in cycle N appears on cdb_*_o in cycle N+1 for exactly one cycle.
  - Lanes with no new grant return to valid=0 in the next cycle.
- Pointer update, registered:
  - If there are >=1 grants, rr_ptr <= (index of the last granted requester + 1) mod NUM_REQ.
  - If there are 0 grants, rr_ptr is unchanged.
  - Wrap: the last granted index NUM_REQ-1 gives rr_ptr = 0.
- Full load:
  - With more than NUM_CDB valid requesters, the excess see ready=0 and retry.
  - Every continuously-valid requester is granted within ceil(NUM_REQ/NUM_CDB) cycles. No starvation.
- Flush (flush_i=1 in cycle N):
  - req_ready_o = 0 in cycle N; no grants.
  - cdb_valid_o = 0, cdb_tag_o = 0, cdb_val_o = 0 and grant_cnt_o = 0 in cycle N+1.
  - Results already on the lanes in cycle N still broadcast in cycle N.
  - rr_ptr is unchanged.
- Simultaneous events:
  - Flush with valid requests: flush wins.
  - Reset deasserting mid-stream: the first grant happens in the first cycle with rst_n high, starting from requester 0.
- Duplicate tags across requesters are not checked; the arbiter is payload-agnostic.
- grant_cnt_o is registered alongside the lanes.

Test Plan:
- Reset, then req_valid_i=6'b000101 with tags 3 and 7, rr_ptr=0 -> ready=000101. Next cycle: lane0 tag 3, lane1 tag 7, cdb_valid_o=0011, grant_cnt_o=2. rr_ptr becomes 3.
- All 6 requesters valid, held, from rr_ptr=0:
  - Cycle 1 grants 0,1,2,3; rr_ptr becomes 4.
  - Cycle 2: only 4,5 remain valid -> both granted on lanes 0,1; rr_ptr becomes 0.
- Persistent valid on all 6 for 3 cycles with no drop of valid after grant (producer re-issues) -> grant sets are {0,1,2,3}, {4,5,0,1}, {2,3,4,5}. Each requester is granted at least once per 2 cycles.
- Single requester 5 valid, rr_ptr=5 -> granted on lane 0; rr_ptr wraps to 0.
- flush_i=1 with 4 valid requesters -> req_ready_o=0 that cycle. cdb_valid_o=0 and payload 0 next cycle; rr_ptr unchanged.
- rst_n asserted low asynchronously mid-cycle while lanes are valid -> cdb_valid_o drops to 0 immediately, without waiting for a clock edge.
